// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: autonomous RGB LED sequencer (static/rotate/blink/bounce) driven by a one-shot config word
module led_seq_ctrl #(
    parameter int NB_GPIOS = 32,
    parameter int NB_RGB   = 12,
    parameter int BASE_DIV = 1000000,
    parameter int NB_DIV   = 20
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic [NB_GPIOS-1:0] i_ctrl,
    input  logic                i_load,
    input  logic                i_hold,
    output logic [NB_RGB-1:0]   o_rgb,
    output logic                o_tick,
    output logic [1:0]          o_pos,
    output logic                o_active
);
    localparam logic [NB_DIV-1:0] DIV_MAX = NB_DIV'(BASE_DIV - 1);

    typedef enum logic [2:0] {IDLE, STATIC, ROTATE, BLINK, BOUNCE} state_t;

    state_t            state, state_nx;
    logic [NB_RGB-1:0] pattern, pattern_nx, work, work_nx, rgb_nx;
    logic [3:0]        speed, speed_nx, step, step_nx;
    logic [NB_DIV-1:0] presc, presc_nx;
    logic [1:0]        pos, pos_nx;
    logic              dir, dir_nx, phase, phase_nx, active_nx;
    logic              running, wrap, tick;
    logic              unused_ctrl;

    assign unused_ctrl = ^i_ctrl[NB_GPIOS-1:19];
    assign o_pos       = pos;

    always_comb begin
        running    = state inside {ROTATE, BLINK, BOUNCE};
        wrap       = presc == DIV_MAX;
        tick       = running && !i_hold && !i_load && wrap && step == speed;
        state_nx   = state;
        pattern_nx = pattern;
        speed_nx   = speed;
        presc_nx   = presc;
        step_nx    = step;
        pos_nx     = pos;
        dir_nx     = dir;
        phase_nx   = phase;
        work_nx    = work;
        active_nx  = o_active;
        if (i_load) begin
            pattern_nx = i_ctrl[NB_RGB-1:0];
            speed_nx   = i_ctrl[18:15];
            state_nx   = !i_ctrl[14]           ? IDLE   :
                         i_ctrl[13:12] == 2'd0 ? STATIC :
                         i_ctrl[13:12] == 2'd1 ? ROTATE :
                         i_ctrl[13:12] == 2'd2 ? BLINK  : BOUNCE;
            presc_nx   = '0;
            step_nx    = '0;
            pos_nx     = '0;
            dir_nx     = 1'b0;
            phase_nx   = 1'b1;
            work_nx    = i_ctrl[NB_RGB-1:0];
            active_nx  = i_ctrl[14] && i_ctrl[13:12] != 2'd0;
        end else if (running && !i_hold) begin
            presc_nx = wrap ? '0 : presc + NB_DIV'(1);
            step_nx  = !wrap ? step : step == speed ? 4'd0 : step + 4'd1;
            if (tick) begin
                work_nx  = state == ROTATE ? {work[NB_RGB-4:0], work[NB_RGB-1:NB_RGB-3]} : work;
                phase_nx = state == BLINK ? !phase : phase;
                pos_nx   = state == ROTATE ? pos + 2'd1 :
                           state == BOUNCE ? (dir ? pos - 2'd1 : pos + 2'd1) : pos;
                // direction flips on the step that lands on an end LED
                dir_nx   = state == BOUNCE && (pos_nx == 2'd3 || pos_nx == 2'd0) ? !dir : dir;
            end
        end
        rgb_nx = state_nx == STATIC ? pattern_nx :
                 state_nx == ROTATE ? work_nx :
                 state_nx == BLINK  ? (phase_nx ? pattern_nx : '0) :
                 state_nx == BOUNCE ? NB_RGB'(pattern_nx[2:0]) << (3 * pos_nx) : '0;
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state    <= IDLE;
            pattern  <= '0;
            speed    <= '0;
            presc    <= '0;
            step     <= '0;
            pos      <= '0;
            dir      <= 1'b0;
            phase    <= 1'b1;
            work     <= '0;
            o_rgb    <= '0;
            o_tick   <= 1'b0;
            o_active <= 1'b0;
        end else begin
            state    <= state_nx;
            pattern  <= pattern_nx;
            speed    <= speed_nx;
            presc    <= presc_nx;
            step     <= step_nx;
            pos      <= pos_nx;
            dir      <= dir_nx;
            phase    <= phase_nx;
            work     <= work_nx;
            o_rgb    <= rgb_nx;
            o_tick   <= tick;
            o_active <= active_nx;
        end
    end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed + random checks of led_seq_ctrl against a cycle-count reference model
module tb_led_seq_ctrl;
    logic        clock = 1'b0;
    logic        i_reset, i_load, i_hold;
    logic [31:0] i_ctrl;
    logic [11:0] o_rgb;
    logic        o_tick, o_active;
    logic [1:0]  o_pos;

    led_seq_ctrl #(.NB_GPIOS(32), .NB_RGB(12), .BASE_DIV(4), .NB_DIV(3)) dut (
        .clock(clock), .i_reset(i_reset), .i_ctrl(i_ctrl), .i_load(i_load), .i_hold(i_hold),
        .o_rgb(o_rgb), .o_tick(o_tick), .o_pos(o_pos), .o_active(o_active)
    );

    always #5 clock = ~clock;

    int          passed = 0, total = 0;
    logic        m_en = 1'b0;
    logic [1:0]  m_mode = 2'd0;
    logic [11:0] m_pat = 12'd0;
    int          m_speed = 0, c = 0, k = 0;
    logic        e_tick;
    logic [11:0] e_rgb;
    logic [1:0]  e_pos;
    logic        e_active;
    int          bounce_tbl[6] = '{0, 1, 2, 3, 2, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Outputs are a pure function of the loaded config and the number of steps taken since load.
    task automatic model(input logic rst, input logic ld, input logic [31:0] ctrl, input logic hold);
        int p;
        e_tick = 1'b0;
        if (rst) begin
            m_en = 0; m_mode = 0; m_pat = 0; m_speed = 0; c = 0; k = 0;
        end else if (ld) begin
            m_en = ctrl[14]; m_mode = ctrl[13:12]; m_pat = ctrl[11:0];
            m_speed = int'(ctrl[18:15]); c = 0; k = 0;
        end else if (m_en && m_mode != 2'd0 && !hold) begin
            c++;
            if (c % ((m_speed + 1) * 4) == 0) begin
                e_tick = 1'b1;
                k++;
            end
        end
        e_active = m_en && m_mode != 2'd0;
        e_rgb = 12'd0;
        e_pos = 2'd0;
        if (m_en) begin
            case (m_mode)
                2'd0: e_rgb = m_pat;
                2'd1: begin
                    for (int n = 0; n < 4; n++) e_rgb[3*n +: 3] = m_pat[3*((n - k % 4 + 4) % 4) +: 3];
                    e_pos = 2'(k % 4);
                end
                2'd2: e_rgb = (k % 2 == 0) ? m_pat : 12'd0;
                default: begin
                    p = bounce_tbl[k % 6];
                    e_rgb[3*p +: 3] = m_pat[2:0];
                    e_pos = 2'(p);
                end
            endcase
        end
    endtask

    task automatic cyc(input logic rst, input logic ld, input logic [31:0] ctrl, input logic hold);
        i_reset = rst; i_load = ld; i_ctrl = ctrl; i_hold = hold;
        @(posedge clock);
        model(rst, ld, ctrl, hold);
        #1;
        check("rgb", 32'(o_rgb), 32'(e_rgb));
        check("tick", 32'(o_tick), 32'(e_tick));
        check("pos", 32'(o_pos), 32'(e_pos));
        check("active", 32'(o_active), 32'(e_active));
        i_load = 1'b0;
    endtask

    task automatic run(input int n, input logic hold);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, i_ctrl, hold);
    endtask

    initial begin
        logic [31:0] r;
        i_reset = 1'b1; i_load = 1'b0; i_hold = 1'b0; i_ctrl = 32'd0;
        repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        check("reset_rgb", 32'(o_rgb), 32'd0);
        // rotate 007, speed 0
        cyc(1'b0, 1'b1, 32'h0000_5007, 1'b0);
        check("rot_load_rgb", 32'(o_rgb), 32'h007);
        run(3, 1'b0);
        check("rot_no_tick_yet", 32'(o_tick), 32'd0);
        run(1, 1'b0);
        check("rot_step1_rgb", 32'(o_rgb), 32'h038);
        check("rot_step1_tick", 32'(o_tick), 32'd1);
        run(12, 1'b0);
        check("rot_wrap_rgb", 32'(o_rgb), 32'h007);
        // hold right after a tick, then resume
        run(1, 1'b0);
        run(10, 1'b1);
        run(8, 1'b0);
        // blink FFF, speed 1
        cyc(1'b0, 1'b1, 32'h0000_EFFF, 1'b0);
        check("blink_on", 32'(o_rgb), 32'hFFF);
        run(34, 1'b0);
        // bounce colour 100, reset at pos 2
        cyc(1'b0, 1'b1, 32'h0000_7004, 1'b0);
        run(8, 1'b0);
        check("bounce_pos2", 32'(o_pos), 32'd2);
        check("bounce_rgb2", 32'(o_rgb), 32'h100);
        cyc(1'b1, 1'b1, 32'h0000_5007, 1'b0);
        check("reset_mid_rgb", 32'(o_rgb), 32'd0);
        run(10, 1'b0);
        // full bounce sweep
        cyc(1'b0, 1'b1, 32'h0000_7004, 1'b0);
        run(30, 1'b0);
        // load coincident with a pending tick
        cyc(1'b0, 1'b1, 32'h0000_5007, 1'b0);
        run(3, 1'b0);
        cyc(1'b0, 1'b1, 32'h0000_40C0, 1'b0);
        check("load_tick_suppressed", 32'(o_tick), 32'd0);
        check("load_static_rgb", 32'(o_rgb), 32'h0C0);
        run(6, 1'b0);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            r[14] = ($urandom_range(0, 3) != 0);
            r[18:15] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, r, $urandom_range(0, 7) == 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
